// File: rtl/ula_pkg.sv
// Shared opcode map, FSM states and multiply/divide selectors for the multi-cycle ALU.
// Opcode values are independent of WIDTH so the control unit decode never changes.
package ula_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_AND   = 5'd0;
    localparam logic [OP_W-1:0] OP_OR    = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD   = 5'd2;
    localparam logic [OP_W-1:0] OP_PASSA = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd6;
    localparam logic [OP_W-1:0] OP_SLT   = 5'd7;
    localparam logic [OP_W-1:0] OP_LUI   = 5'd8;
    localparam logic [OP_W-1:0] OP_SLL   = 5'd9;
    localparam logic [OP_W-1:0] OP_SRL   = 5'd10;
    localparam logic [OP_W-1:0] OP_NOR   = 5'd11;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd12;
    localparam logic [OP_W-1:0] OP_SRA   = 5'd13;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'd14;
    localparam logic [OP_W-1:0] OP_MFHI  = 5'd15;
    localparam logic [OP_W-1:0] OP_MFLO  = 5'd16;
    localparam logic [OP_W-1:0] OP_MULT  = 5'd17;
    localparam logic [OP_W-1:0] OP_MULTU = 5'd18;
    localparam logic [OP_W-1:0] OP_DIV   = 5'd19;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'd20;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } mdop_e;

    function automatic logic isMultiCycle(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ula_if.sv
// Execute-stage ALU bus between the control unit (master) and the ALU (slave).
interface ula_if
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               START;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] SHAMT;
    logic [OP_W-1:0]    OP;
    logic [WIDTH-1:0]   S;
    logic               Z;
    logic               OV;
    logic               BUSY;
    logic               DONE;

    modport master (
        output START, A, B, SHAMT, OP,
        input  S, Z, OV, BUSY, DONE
    );

    modport slave (
        input  START, A, B, SHAMT, OP,
        output S, Z, OV, BUSY, DONE
    );

endinterface

// File: rtl/ula_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per clock.
// Signed operations run on magnitudes; signs are restored combinationally in FIN.
module ula_muldiv
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  mdop_e            op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               isMul_q, isMul_d;
    logic               negLo_q, negLo_d;
    logic               negHi_q, negHi_d;

    logic               isSigned, isMulIn, aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic [2*WIDTH-1:0] product, prodFix;

    assign isSigned = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign isMulIn  = (op_i == MD_MULT) || (op_i == MD_MULTU);
    assign aNeg     = isSigned && a_i[WIDTH-1];
    assign bNeg     = isSigned && b_i[WIDTH-1];
    assign aMag     = aNeg ? -a_i : a_i;
    assign bMag     = bNeg ? -b_i : b_i;

    // Multiply keeps the multiplier in LO and shifts the partial product in from HI.
    assign mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign divShift = {hi_q, lo_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opnd_q};
    assign product  = {hi_q, lo_q};
    assign prodFix  = negLo_q ? -product : product;
    assign busy_o   = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            isMul_q <= 1'b0;
            negLo_q <= 1'b0;
            negHi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            isMul_q <= isMul_d;
            negLo_q <= negLo_d;
            negHi_q <= negHi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        isMul_d = isMul_q;
        negLo_d = negLo_q;
        negHi_d = negHi_q;
        done_o  = 1'b0;
        hi_o    = hi_q;
        lo_o    = lo_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    isMul_d = isMulIn;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    if (isMulIn) begin
                        opnd_d  = aMag;
                        hi_d    = '0;
                        lo_d    = bMag;
                        negLo_d = aNeg ^ bNeg;
                        negHi_d = 1'b0;
                        state_d = ITER;
                    end else if (b_i == '0) begin
                        // Division by zero: results are preloaded and FIN passes them through.
                        hi_d    = a_i;
                        lo_d    = '1;
                        negLo_d = 1'b0;
                        negHi_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        opnd_d  = bMag;
                        hi_d    = '0;
                        lo_d    = aMag;
                        negLo_d = aNeg ^ bNeg;
                        negHi_d = aNeg;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (isMul_q) begin
                    {hi_d, lo_d} = {mulSum, lo_q[WIDTH-1:1]};
                end else if (!divDiff[WIDTH]) begin
                    hi_d = divDiff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = divShift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
                if (isMul_q) begin
                    {hi_o, lo_o} = prodFix;
                end else begin
                    hi_o = negHi_q ? -hi_q : hi_q;
                    lo_o = negLo_q ? -lo_q : lo_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Execute-stage ALU: registered single-cycle ops plus iterative MULT/DIV into HI/LO.
// BUSY tells the control unit to stall; DONE pulses when S/Z/OV (and HI/LO) are fresh.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic  clock,
    input logic  reset,
    ula_if.slave bus
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             z_q, z_d;
    logic             ov_q, ov_d;
    logic             done_q, done_d;

    logic             busy, accept, isMulti, mdStart, mdDone;
    logic [WIDTH-1:0] mdHi, mdLo;
    mdop_e            mdOp;
    logic [WIDTH-1:0] addRes, subRes, aluRes;
    logic             aluOv;

    assign addRes  = bus.A + bus.B;
    assign subRes  = bus.A - bus.B;
    assign isMulti = isMultiCycle(bus.OP);
    assign accept  = bus.START && !busy;
    assign mdStart = accept && isMulti;

    // Single-cycle datapath; MFHI/MFLO read the architectural HI/LO registers.
    always_comb begin
        aluRes = '0;
        aluOv  = 1'b0;
        case (bus.OP)
            OP_AND:   aluRes = bus.A & bus.B;
            OP_OR:    aluRes = bus.A | bus.B;
            OP_ADD: begin
                aluRes = addRes;
                aluOv  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (addRes[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_PASSA: aluRes = bus.A;
            OP_SUB: begin
                aluRes = subRes;
                aluOv  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (subRes[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_LUI:   aluRes = bus.B << HALF;
            OP_SLL:   aluRes = bus.A << bus.SHAMT;
            OP_SRL:   aluRes = bus.A >> bus.SHAMT;
            OP_NOR:   aluRes = ~(bus.A | bus.B);
            OP_XOR:   aluRes = bus.A ^ bus.B;
            OP_SRA:   aluRes = $unsigned($signed(bus.A) >>> bus.SHAMT);
            OP_SLTU:  aluRes = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_MFHI:  aluRes = hi_q;
            OP_MFLO:  aluRes = lo_q;
            default: begin
                aluRes = '0;
                aluOv  = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (bus.OP)
            OP_MULTU: mdOp = MD_MULTU;
            OP_DIV:   mdOp = MD_DIV;
            OP_DIVU:  mdOp = MD_DIVU;
            default:  mdOp = MD_MULT;
        endcase
    end

    ula_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clock   (clock),
        .reset   (reset),
        .start_i (mdStart),
        .op_i    (mdOp),
        .a_i     (bus.A),
        .b_i     (bus.B),
        .busy_o  (busy),
        .done_o  (mdDone),
        .hi_o    (mdHi),
        .lo_o    (mdLo)
    );

    // A multi-cycle completion and a single-cycle accept never coincide: FIN keeps BUSY high.
    always_comb begin
        s_d    = s_q;
        z_d    = z_q;
        ov_d   = ov_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (mdDone) begin
            hi_d   = mdHi;
            lo_d   = mdLo;
            s_d    = mdLo;
            z_d    = (mdLo == '0);
            ov_d   = 1'b0;
            done_d = 1'b1;
        end else if (accept && !isMulti) begin
            s_d    = aluRes;
            z_d    = (aluRes == '0);
            ov_d   = aluOv;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q    <= '0;
            z_q    <= 1'b1;
            ov_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            z_q    <= z_d;
            ov_q   <= ov_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.Z    = z_q;
    assign bus.OV   = ov_q;
    assign bus.BUSY = busy;
    assign bus.DONE = done_q;

endmodule
